// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//   ALU control decoder with a sequencer that stalls on multi-cycle MULT/DIV.
//   A func/uc_aluop pair is accepted when in_valid and in_ready are both high.
//   The decoded operation appears one cycle later on alu_op with a one-cycle
//   op_valid pulse. An accepted MULT or DIV holds the block busy for
//   MD_CYCLES cycles, and md_done pulses in the last of those cycles.
//
// Parameters
//   MD_CYCLES  busy window length for MULT/DIV (2..15)
//   OP_W       alu_op width (3 or 4; 3 keeps the low bits of each code)
//   EXT_EN     1 enables the XOR/NOR func decodes (needs OP_W=4)
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     a func/uc_aluop pair is presented
//   func         R-type function field
//   uc_aluop     op class from the main control unit
//   in_ready     pair can be accepted this cycle (registered, IDLE only)
//   op_valid     one-cycle pulse per accepted pair
//   alu_op       registered ALU operation code
//   md_busy      MULT/DIV in progress
//   md_done      pulse in the final MULT/DIV cycle
//   illegal      last accepted pair did not decode
//   illegal_cnt  saturating count of illegal pairs
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
  parameter int MD_CYCLES = 4,
  parameter int OP_W      = 4,
  parameter int EXT_EN    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [5:0]      func,
  input  logic [2:0]      uc_aluop,
  output logic            in_ready,
  output logic            op_valid,
  output logic [OP_W-1:0] alu_op,
  output logic            md_busy,
  output logic            md_done,
  output logic            illegal,
  output logic [7:0]      illegal_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_AND  = 4'h0;
  localparam logic [3:0] C_OR   = 4'h1;
  localparam logic [3:0] C_ADD  = 4'h2;
  localparam logic [3:0] C_SUB  = 4'h3;
  localparam logic [3:0] C_SLT  = 4'h4;
  localparam logic [3:0] C_DIV  = 4'h5;
  localparam logic [3:0] C_NOP  = 4'h6;
  localparam logic [3:0] C_MULT = 4'h7;
  localparam logic [3:0] C_XOR  = 4'h8;
  localparam logic [3:0] C_NOR  = 4'h9;

  // Entry value of the busy down-counter: MD_BUSY lasts MD_CYCLES-1 cycles,
  // MD_DONE supplies the last one.
  localparam logic [3:0] CNT_LOAD = 4'(MD_CYCLES - 2);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              op_valid_q, op_valid_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              md_busy_q, md_busy_d;
  logic              md_done_q, md_done_d;
  logic              illegal_q, illegal_d;
  logic [7:0]        illegal_cnt_q, illegal_cnt_d;

  logic [3:0]        dec_code;
  logic              dec_ill;
  logic              dec_md;
  logic              accept;

  // Pure decode of the presented pair; only consumed on accept.
  always_comb begin
    dec_code = C_NOP;
    dec_ill  = 1'b0;
    if (uc_aluop == 3'b111) begin
      case (func)
        6'b100100: dec_code = C_AND;
        6'b100101: dec_code = C_OR;
        6'b100000: dec_code = C_ADD;
        6'b100010: dec_code = C_SUB;
        6'b101010: dec_code = C_SLT;
        6'b011010: dec_code = C_DIV;
        6'b000000: dec_code = C_NOP;
        6'b011000: dec_code = C_MULT;
        6'b100110: begin
          if (EXT_EN != 0) dec_code = C_XOR;
          else             dec_ill  = 1'b1;
        end
        6'b100111: begin
          if (EXT_EN != 0) dec_code = C_NOR;
          else             dec_ill  = 1'b1;
        end
        default:   dec_ill = 1'b1;
      endcase
    end else begin
      case (uc_aluop)
        3'b000:  dec_code = C_ADD;
        3'b001:  dec_code = C_SUB;
        3'b010:  dec_code = C_AND;
        3'b011:  dec_code = C_OR;
        3'b100:  dec_code = C_SLT;
        default: dec_ill  = 1'b1;
      endcase
    end
    if (dec_ill) dec_code = C_NOP;
    dec_md = !dec_ill && (dec_code == C_DIV || dec_code == C_MULT);
  end

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_op_d      = alu_op_q;
    op_valid_d    = 1'b0;
    illegal_d     = illegal_q;
    illegal_cnt_d = illegal_cnt_q;

    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (accept) begin
          alu_op_d   = dec_code[OP_W-1:0];
          op_valid_d = 1'b1;
          illegal_d  = dec_ill;
          if (dec_ill && illegal_cnt_q != 8'hFF)
            illegal_cnt_d = illegal_cnt_q + 8'd1;
          if (dec_md) begin
            state_d = MD_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      MD_BUSY: begin
        if (cnt_q == 4'd0) state_d = MD_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      MD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Status outputs are registered versions of the next state, so they
    // line up with the state they describe.
    in_ready_d = (state_d == IDLE);
    md_busy_d  = (state_d != IDLE);
    md_done_d  = (state_d == MD_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      in_ready_q    <= 1'b0;
      op_valid_q    <= 1'b0;
      alu_op_q      <= C_NOP[OP_W-1:0];
      md_busy_q     <= 1'b0;
      md_done_q     <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      op_valid_q    <= op_valid_d;
      alu_op_q      <= alu_op_d;
      md_busy_q     <= md_busy_d;
      md_done_q     <= md_done_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign op_valid    = op_valid_q;
  assign alu_op      = alu_op_q;
  assign md_busy     = md_busy_q;
  assign md_done     = md_done_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//   Directed bench for alu_ctrl_seq. A default instance (MD_CYCLES=4, OP_W=4,
//   EXT_EN=1) and an EXT_EN=0 instance share the same stimulus; the second
//   one is only compared on the XOR/NOR func codes.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] func;
  logic [2:0] uc_aluop;

  logic       in_ready, op_valid, md_busy, md_done, illegal;
  logic [3:0] alu_op;
  logic [7:0] illegal_cnt;

  logic       b_in_ready, b_op_valid, b_md_busy, b_md_done, b_illegal;
  logic [3:0] b_alu_op;
  logic [7:0] b_illegal_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.MD_CYCLES(4), .OP_W(4), .EXT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .func(func),
    .uc_aluop(uc_aluop), .in_ready(in_ready), .op_valid(op_valid),
    .alu_op(alu_op), .md_busy(md_busy), .md_done(md_done),
    .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  alu_ctrl_seq #(.MD_CYCLES(4), .OP_W(4), .EXT_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .func(func),
    .uc_aluop(uc_aluop), .in_ready(b_in_ready), .op_valid(b_op_valid),
    .alu_op(b_alu_op), .md_busy(b_md_busy), .md_done(b_md_done),
    .illegal(b_illegal), .illegal_cnt(b_illegal_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present one pair for one edge, then check
  // the registered result.
  task automatic send(input string tag, input logic [2:0] op, input logic [5:0] f,
                      input logic [3:0] exp_op, input logic exp_ill);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    uc_aluop = op;
    func     = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, op_valid}, 32'd1);
    chk({tag, "_op"}, {28'd0, alu_op}, {28'd0, exp_op});
    chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
    $display("txn %s: uc_aluop=%b func=%b -> alu_op=%b illegal=%b cnt=%0d busy=%b",
             tag, op, f, alu_op, illegal, illegal_cnt, md_busy);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    func     = 6'd0;
    uc_aluop = 3'd0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op",    {28'd0, alu_op}, 32'h6);
    chk("rst_busy",  {31'd0, md_busy}, 32'd0);
    chk("rst_done",  {31'd0, md_done}, 32'd0);
    chk("rst_ill",   {31'd0, illegal}, 32'd0);
    chk("rst_cnt",   {24'd0, illegal_cnt}, 32'd0);

    rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, in_ready}, 32'd1);

    // Base func decodes in order
    send("and",  3'b111, 6'b100100, 4'h0, 1'b0);
    send("or",   3'b111, 6'b100101, 4'h1, 1'b0);
    send("add",  3'b111, 6'b100000, 4'h2, 1'b0);
    send("sub",  3'b111, 6'b100010, 4'h3, 1'b0);
    send("slt",  3'b111, 6'b101010, 4'h4, 1'b0);
    send("div",  3'b111, 6'b011010, 4'h5, 1'b0);
    chk("div_busy", {31'd0, md_busy}, 32'd1);
    send("nop",  3'b111, 6'b000000, 4'h6, 1'b0);
    send("mult", 3'b111, 6'b011000, 4'h7, 1'b0);
    chk("mult_busy", {31'd0, md_busy}, 32'd1);

    // Class decodes
    send("c_add", 3'b000, 6'b111111, 4'h2, 1'b0);
    send("c_sub", 3'b001, 6'b000000, 4'h3, 1'b0);
    send("c_and", 3'b010, 6'b100000, 4'h0, 1'b0);
    send("c_or",  3'b011, 6'b100000, 4'h1, 1'b0);
    send("c_slt", 3'b100, 6'b100000, 4'h4, 1'b0);

    // MULT busy window with in_valid held high (ADD) throughout
    send("mult_t", 3'b111, 6'b011000, 4'h7, 1'b0);
    uc_aluop = 3'b000;
    func     = 6'd0;
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("w%0d_busy", k),  {31'd0, md_busy}, 32'd1);
      chk($sformatf("w%0d_done", k),  {31'd0, md_done}, {31'd0, k == 4});
      chk($sformatf("w%0d_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("w%0d_valid", k), {31'd0, op_valid}, {31'd0, k == 1});
      chk($sformatf("w%0d_op", k),    {28'd0, alu_op}, 32'h7);
      tick();
    end
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_busy",  {31'd0, md_busy}, 32'd0);
    chk("t5_valid", {31'd0, op_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t6_valid", {31'd0, op_valid}, 32'd1);
    chk("t6_op",    {28'd0, alu_op}, 32'h2);
    $display("txn mult_window: add after busy -> alu_op=%b", alu_op);

    // Illegal handling
    send("undef", 3'b111, 6'b111111, 4'h6, 1'b1);
    chk("undef_cnt", {24'd0, illegal_cnt}, 32'd1);
    send("cls110", 3'b110, 6'b100000, 4'h6, 1'b1);
    chk("cls110_cnt", {24'd0, illegal_cnt}, 32'd2);
    send("clr_add", 3'b000, 6'b000000, 4'h2, 1'b0);
    chk("clr_cnt", {24'd0, illegal_cnt}, 32'd2);

    // Extended decodes; EXT_EN=0 instance must flag them
    send("xor", 3'b111, 6'b100110, 4'h8, 1'b0);
    chk("b_xor_ill", {31'd0, b_illegal}, 32'd1);
    chk("b_xor_op",  {28'd0, b_alu_op}, 32'h6);
    send("nor", 3'b111, 6'b100111, 4'h9, 1'b0);
    chk("b_nor_ill", {31'd0, b_illegal}, 32'd1);
    chk("b_nor_op",  {28'd0, b_alu_op}, 32'h6);
    chk("b_cnt",     {24'd0, b_illegal_cnt}, 32'd4);

    // 300 consecutive illegal accepts; count starts at 2
    uc_aluop = 3'b101;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) chk("sat_mid", {24'd0, illegal_cnt}, 32'd102);
    end
    in_valid = 1'b0;
    chk("sat_cnt", {24'd0, illegal_cnt}, 32'd255);
    chk("sat_ill", {31'd0, illegal}, 32'd1);
    $display("txn saturate: 300 illegal accepts -> cnt=%0d", illegal_cnt);

    // Reset in the middle of a DIV
    send("div_rst", 3'b111, 6'b011010, 4'h5, 1'b0);
    tick();
    chk("abort_busy2", {31'd0, md_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", {31'd0, md_busy}, 32'd0);
    chk("abort_done", {31'd0, md_done}, 32'd0);
    chk("abort_op",   {28'd0, alu_op}, 32'h6);
    chk("abort_rdy",  {31'd0, in_ready}, 32'd0);
    chk("abort_cnt",  {24'd0, illegal_cnt}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_done%0d", k), {31'd0, md_done}, 32'd0);
    end
    chk("post_ready", {31'd0, in_ready}, 32'd1);
    $display("txn abort: div aborted by reset -> busy=%b op=%b", md_busy, alu_op);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter MD_CYCLES, default 4: cycles the MULT/DIV multi-cycle unit is held busy; legal range 2..15.
REQ-002 Parameter OP_W, default 4: width of alu_op; legal values 3 or 4.
REQ-003 Parameter EXT_EN, default 1: 1 enables the XOR/NOR decodes; EXT_EN=1 requires OP_W=4.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low, sampled on the clk rising edge.
REQ-006 in_valid  in  1  a func/uc_aluop pair is presented.
REQ-007 func  in  6  R-type function field.
REQ-008 uc_aluop  in  3  ALU op class from the main control unit.
REQ-009 in_ready  out  1  block accepts a pair this cycle.
REQ-010 op_valid  out  1  alu_op is valid this cycle; a one-cycle pulse per accepted pair.
REQ-011 alu_op  out  OP_W  registered ALU operation code.
REQ-012 md_busy  out  1  a MULT/DIV is in progress; the pipeline stalls on it.
REQ-013 md_done  out  1  one-cycle pulse in the final MULT/DIV cycle.
REQ-014 illegal  out  1  the last accepted pair did not decode.
REQ-015 illegal_cnt  out  8  saturating count of illegal pairs.

Function
REQ-016 Accept rule: a pair is accepted when in_valid=1 and in_ready=1; in_ready=1 only in IDLE.
REQ-017 Latency: alu_op, op_valid and illegal update in the cycle after acceptance; there is no combinational path from input to output.
REQ-018 uc_aluop=111 decodes func as follows: 100100 -> AND 0000; 100101 -> OR 0001; 100000 -> ADD 0010; 100010 -> SUB 0011; 101010 -> SLT 0100; 011010 -> DIV 0101; 000000 -> NOP 0110; 011000 -> MULT 0111.
REQ-019 EXT_EN=1 adds two func decodes: 100110 -> XOR 1000; 100111 -> NOR 1001.
REQ-020 For any other uc_aluop, func is ignored and the class maps as follows: 000 -> ADD; 001 -> SUB; 010 -> AND; 011 -> OR; 100 -> SLT; 101, 110 -> illegal.
REQ-021 OP_W=3: the output is the low 3 bits of the codes above.
REQ-022 An undefined func, or any illegal case, gives alu_op=NOP, illegal=1, and illegal_cnt increments, saturating at 255; op_valid still pulses.
REQ-023 alu_op holds its last value between accepts; it is never left undriven or latched.
REQ-024 FSM has 3 states: IDLE, MD_BUSY, MD_DONE.
REQ-025 From IDLE, an accepted DIV or MULT -> MD_BUSY; any other accepted pair -> IDLE.
REQ-026 MD_BUSY: a down-counter loads MD_CYCLES-2 on entry; the state moves to MD_DONE when the counter reaches 0.
REQ-027 MD_DONE lasts exactly one cycle, then the state returns to IDLE.
REQ-028 md_busy=1 in MD_BUSY and MD_DONE; md_done=1 only in MD_DONE.
REQ-029 The total busy window is exactly MD_CYCLES cycles, starting the cycle after acceptance.
REQ-030 During the busy window alu_op holds the MULT/DIV code, op_valid=0, and in_ready=0; in_valid is ignored.
REQ-031 The first accept is possible in the cycle after MD_DONE.
REQ-032 in_valid=1 held while busy does not create a second op_valid pulse.
REQ-033 illegal clears to 0 on the next legal accept.

Reset
REQ-034 rst_n=0 at a clock edge forces the following: state=IDLE, counter=0, alu_op=NOP 0110, op_valid=0, md_busy=0, md_done=0, illegal=0, illegal_cnt=0.
REQ-035 rst_n=0 overrides everything, including a MULT/DIV in progress; the aborted operation never produces md_done.
REQ-036 When reset is asserted, in_ready=0; when reset is released, in_ready=1 in IDLE.

Verification
REQ-037 Reset, then uc_aluop=111 with each of the 8 base func codes back-to-back -> one op_valid per cycle with codes 0000-0111 in order; md_busy=1 after 0101 and after 0111.
REQ-038 MD_CYCLES=4, accept MULT (011000) at cycle t -> md_busy=1 for t+1..t+4, md_done=1 only at t+4, in_ready=1 at t+5; an ADD accepted at t+5 gives op_valid=1 with alu_op 0010 at t+6.
REQ-039 uc_aluop=111 with func=111111 (undefined), then uc_aluop=110 -> two NOP outputs with illegal=1 and illegal_cnt=2; a following ADD clears illegal and holds the count at 2.
REQ-040 300 consecutive illegal accepts -> illegal_cnt saturates at 255 and does not wrap to 0.
REQ-041 Accept DIV; drive rst_n=0 at busy cycle 2 -> next cycle: IDLE, md_busy=0, alu_op=0110, no md_done pulse.
REQ-042 EXT_EN=1, OP_W=4: func 100110 -> 1000 and func 100111 -> 1001; EXT_EN=0: both func codes -> illegal=1.
